lfsr_rand_arbiter: RTL and testbench
====================================

Name: lfsr_rand_arbiter

Overview:
- Shares one external 8-bit LFSR between NUM_REQ requesters, such as note spawner and lane selector.
- Grants round-robin.
- Steps the LFSR STEPS times per draw, so each delivered byte is fully fresh.
- Applies per-requester range limiting by rejection sampling, and returns the result with a one-cycle valid/grant pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- STEPS, 8, LFSR shifts per draw (1..15)
- MAX_TRIES, 4, draws attempted before fallback (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  level request, one bit per requester; held until its gnt bit pulses
- limit  in  8*NUM_REQ  per-requester exclusive upper bound, requester i at [8i+7:8i]; 0 = no limit
- lfsr_en  out  1  step enable to the LFSR
- lfsr_value  in  8  LFSR current value (registered in the LFSR)
- gnt  out  NUM_REQ  one-hot grant, one-cycle pulse
- rand_valid  out  1  one-cycle pulse, coincident with gnt
- rand_data  out  8  delivered byte; held until next delivery
- rand_fallback  out  1  high with rand_valid when MAX_TRIES was exhausted

Behaviour:
- Reset values (reset_n=0 at a clk edge): state=IDLE, gnt=0, rand_valid=0, rand_data=0x00, rand_fallback=0, try count=0, round-robin pointer=NUM_REQ-1.
- Reset wins over everything, including a reset asserted mid-STEP or mid-CHECK; any in-flight draw is dropped and no grant is issued.
- lfsr_en is a Moore decode: high only in STEP. The LFSR shares the same reset_n.
- State machine IDLE -> STEP -> CHECK -> (STEP | DONE) -> IDLE:
  - IDLE: if any req bit is set, pick the first set bit searching from pointer+1 with wrap. Latch its index and its limit, clear the try count, go to STEP. If req=0, stay.
  - STEP: exactly STEPS cycles with lfsr_en=1, using an internal step counter, then go to CHECK.
  - CHECK: lfsr_value now reflects all STEPS shifts.
    - Accept if latched limit==0 or lfsr_value < limit (unsigned 8-bit compare). On accept, register rand_data=lfsr_value and rand_fallback=0, go to DONE.
    - Otherwise increment the try count. If the try count reaches MAX_TRIES, register rand_data=0x00 and rand_fallback=1, go to DONE; else go to STEP.
  - DONE: rand_valid=1, gnt[idx]=1 for this one cycle, pointer=idx, then go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> valid at cycle k*(STEPS+1)+1, where k = draws used. This is cycle STEPS+2 for the first draw.
- Back-to-back throughput: one grant per STEPS+3 cycles minimum.
- req changes after latching are ignored; the result is always delivered to the latched index.
- The LFSR never outputs 0x00, so a limit of 0x01 always falls back.
- Simultaneous requests are served strictly round-robin. No requester waits more than NUM_REQ-1 grants.

Optional Feature:
- Macro RAND_IDLE_STIR_EN.
- Defined: lfsr_en is also high in IDLE and DONE, so the LFSR free-runs and draw values depend on request timing. The STEP count and all handshake timing are unchanged.
- Undefined: lfsr_en is high only in STEP, and the sequence is deterministic per request order. All test-plan values below assume the macro is undefined.

Decomposition:
- Shared package rand_pkg:
  - state encoding localparams ST_IDLE, ST_STEP, ST_CHECK, ST_DONE
  - RAND_W=8
  - LIMIT_NONE=8'h00
- One natural sub-module, rr_arbiter: parameter NUM_REQ; inputs req and pointer; outputs grant index and any-request flag. It is combinational, with the pointer register kept in the parent.

Test Plan:
- Reset, then req=4'b0001, limit0=0 -> lfsr_en high for cycles 1-8; rand_valid, gnt=4'b0001, rand_data=0xE0 at cycle 10; rand_fallback=0.
- Rejection: reset, req[0] with limit0=0xD0 -> draw 0xE0 rejected, draw 0xC5 accepted; rand_data=0xC5 with valid at cycle 19; lfsr_en high for 16 cycles total.
- Fallback: MAX_TRIES=2, limit0=0x10 -> draws 0xE0 and 0xC5 both rejected; valid at cycle 19 with rand_data=0x00, rand_fallback=1.
- Round-robin: req=4'b1011 held, limits 0 -> grants in order 4'b0001 (0xE0), 4'b0010 (0xC5), 4'b1000. Then with req=4'b1001 held, next grant is 4'b0001.
- Reset mid-operation: pull reset_n low in cycle 4 of STEP for one cycle -> lfsr_en=0 and all outputs at reset values the next cycle. With req still held, the next grant delivers 0xE0 at 10 cycles after the IDLE re-entry.
- req[0] dropped during STEP -> grant and data are still delivered to requester 0 at the nominal cycle.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared definitions for the LFSR random-number arbiter: draw width,
// "no limit" encoding and the controller state encoding.
package rand_pkg;

    localparam int RAND_W = 8;
    localparam logic [RAND_W-1:0] LIMIT_NONE = 8'h00;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_STEP  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit after pointer,
// wrapping around; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    always_comb begin
        int   c;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            c = int'(pointer) + o;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!found && req[c[IDX_W-1:0]]) begin
                grant_idx = c[IDX_W-1:0];
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter sharing one external 8-bit LFSR, with STEPS shifts per
// draw and rejection sampling against a per-requester limit.
// Define RAND_IDLE_STIR_EN to let the LFSR free-run in IDLE and DONE as well.
module lfsr_rand_arbiter
    import rand_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int STEPS     = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [RAND_W*NUM_REQ-1:0] limit,
    output logic                      lfsr_en,
    input  logic [RAND_W-1:0]         lfsr_value,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rand_valid,
    output logic [RAND_W-1:0]         rand_data,
    output logic                      rand_fallback
);

    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);
    localparam logic [3:0] TRY_LAST  = 4'(MAX_TRIES - 1);

    state_t            state, state_nxt;
    logic [3:0]        step_cnt, try_cnt;
    logic [IDX_W-1:0]  ptr, idx, sel_idx;
    logic              any_req;
    logic [RAND_W-1:0] lim;
    logic              fallback_q;
    logic              accept, last_try;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req),
        .pointer   (ptr),
        .grant_idx (sel_idx),
        .any_req   (any_req)
    );

    assign accept   = (lim == LIMIT_NONE) || (lfsr_value < lim);
    assign last_try = (try_cnt == TRY_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_STEP;
            ST_STEP:  if (step_cnt == STEP_LAST) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = (accept || last_try) ? ST_DONE : ST_STEP;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt           = '0;
        rand_valid    = 1'b0;
        rand_fallback = 1'b0;
`ifdef RAND_IDLE_STIR_EN
        lfsr_en       = (state != ST_CHECK);
`else
        lfsr_en       = (state == ST_STEP);
`endif
        if (state == ST_DONE) begin
            rand_valid    = 1'b1;
            rand_fallback = fallback_q;
            gnt[idx]      = 1'b1;
        end
    end

    // Counters, pointer and the delivered result; reset drops any in-flight draw.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step_cnt   <= '0;
            try_cnt    <= '0;
            ptr        <= IDX_W'(NUM_REQ - 1);
            rand_data  <= '0;
            fallback_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    step_cnt <= '0;
                    try_cnt  <= '0;
                end
                ST_STEP: step_cnt <= step_cnt + 4'd1;
                ST_CHECK: begin
                    step_cnt <= '0;
                    if (accept) begin
                        rand_data  <= lfsr_value;
                        fallback_q <= 1'b0;
                    end else begin
                        try_cnt <= try_cnt + 4'd1;
                        if (last_try) begin
                            rand_data  <= '0;
                            fallback_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: ptr <= idx;
                default: ;
            endcase
        end
    end

    // Requester index and its limit are frozen for the whole draw.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && any_req) begin
            idx <= sel_idx;
            lim <= limit[{sel_idx, 3'b000} +: RAND_W];
        end
    end

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter: external LFSR (x^8+x^4+x^3+x^2+1, seed 0xAA),
// transaction-level reference model plus directed cases with literal values.
module tb_lfsr_rand_arbiter;

    localparam int         NR   = 4;
    localparam int         S    = 8;
    localparam int         MT   = 4;
    localparam logic [7:0] SEED = 8'hAA;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] limit = '0;
    logic        lfsr_en;
    logic [7:0]  lfsr_value;
    logic [3:0]  gnt;
    logic        rand_valid;
    logic [7:0]  rand_data;
    logic        rand_fallback;

    logic [3:0]  req2 = '0;
    logic [31:0] limit2 = '0;
    logic        lfsr_en2;
    logic [7:0]  lfsr_value2;
    logic [3:0]  gnt2;
    logic        rand_valid2;
    logic [7:0]  rand_data2;
    logic        rand_fallback2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(.NUM_REQ(NR), .STEPS(S), .MAX_TRIES(MT)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .limit         (limit),
        .lfsr_en       (lfsr_en),
        .lfsr_value    (lfsr_value),
        .gnt           (gnt),
        .rand_valid    (rand_valid),
        .rand_data     (rand_data),
        .rand_fallback (rand_fallback)
    );

    lfsr_rand_arbiter #(.NUM_REQ(NR), .STEPS(S), .MAX_TRIES(2)) u_dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req2),
        .limit         (limit2),
        .lfsr_en       (lfsr_en2),
        .lfsr_value    (lfsr_value2),
        .gnt           (gnt2),
        .rand_valid    (rand_valid2),
        .rand_data     (rand_data2),
        .rand_fallback (rand_fallback2)
    );

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[3] ^ v[2] ^ v[1]};
    endfunction

    // External LFSRs, sharing reset_n with the arbiters.
    always @(posedge clk) begin
        if (!reset_n) lfsr_value <= SEED;
        else if (lfsr_en) lfsr_value <= lstep(lfsr_value);
    end
    always @(posedge clk) begin
        if (!reset_n) lfsr_value2 <= SEED;
        else if (lfsr_en2) lfsr_value2 <= lstep(lfsr_value2);
    end

    // Reference model: on each grant decision, resolve the whole draw sequence
    // at once and derive the timeline (k draws -> valid k*(S+1)+1 after latch).
    bit         m_busy = 1'b0;
    int         m_t    = 0;
    int         m_d    = 0;
    int         m_idx  = 0;
    int         m_ptr  = NR - 1;
    logic [7:0] m_val  = '0;
    logic [7:0] m_hold = '0;
    logic [7:0] m_lfsr = SEED;
    bit         m_fb   = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_ptr  = NR - 1;
            m_hold = '0;
            m_lfsr = SEED;
        end else if (!m_busy) begin
            if (req != 4'd0) begin
                bit         found;
                bit         acc;
                logic [7:0] lim;
                logic [7:0] v;
                found = 1'b0;
                for (int o = 1; o <= NR; o++) begin
                    int c;
                    c = (m_ptr + o) % NR;
                    if (!found && ((req >> c) & 4'd1) != 4'd0) begin
                        m_idx = c;
                        found = 1'b1;
                    end
                end
                lim  = 8'(limit >> (8 * m_idx));
                v    = m_lfsr;
                acc  = 1'b0;
                m_fb = 1'b1;
                m_val = 8'h00;
                m_d  = MT * (S + 1) + 1;
                for (int k = 1; k <= MT; k++) begin
                    if (!acc) begin
                        for (int s = 0; s < S; s++) v = lstep(v);
                        if (lim == 8'h00 || v < lim) begin
                            acc   = 1'b1;
                            m_val = v;
                            m_fb  = 1'b0;
                            m_d   = k * (S + 1) + 1;
                        end
                    end
                end
                m_lfsr = v;
                m_busy = 1'b1;
                m_t    = 1;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == m_d + 1) m_busy = 1'b0;
        end
        if (m_busy && m_t == m_d) begin
            m_hold = m_val;
            m_ptr  = m_idx;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_valid;
            logic       e_en;
            logic [3:0] e_gnt;
            e_valid = m_busy && (m_t == m_d);
            e_en    = m_busy && (m_t < m_d) && (((m_t - 1) % (S + 1)) < S);
            e_gnt   = e_valid ? 4'(1 << m_idx) : 4'd0;
            check("mdl_lfsr_en", 32'(lfsr_en), 32'(e_en));
            check("mdl_valid", 32'(rand_valid), 32'(e_valid));
            check("mdl_gnt", 32'(gnt), 32'(e_gnt));
            check("mdl_data", 32'(rand_data), 32'(m_hold));
            check("mdl_fallback", 32'(rand_fallback), 32'(e_valid && m_fb));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        req2    = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, input int start, output int c, output int en);
        c  = start;
        en = 0;
        while (!rand_valid && c < maxc) begin
            @(negedge clk);
            c++;
            if (lfsr_en) en++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lfsr_en"}, 32'(lfsr_en), 32'd0);
        check({tag, "_valid"}, 32'(rand_valid), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_data"}, 32'(rand_data), 32'd0);
        check({tag, "_fallback"}, 32'(rand_fallback), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int en;

        do_reset();
        chk_en = 1'b1;
        check_reset_outputs("rst");

        // Single request, no limit: first draw 0xE0 at cycle 10.
        limit = '0;
        req   = 4'b0001;
        wait_valid(60, 0, c, en);
        check("t1_latency", 32'(c), 32'd10);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_data", 32'(rand_data), 32'hE0);
        check("t1_fallback", 32'(rand_fallback), 32'd0);
        check("t1_en_cycles", 32'(en), 32'd8);
        req = '0;

        // Rejection: 0xE0 >= 0xD0, then 0xC5 accepted.
        do_reset();
        limit = 32'h0000_00D0;
        req   = 4'b0001;
        wait_valid(60, 0, c, en);
        check("t2_latency", 32'(c), 32'd19);
        check("t2_data", 32'(rand_data), 32'hC5);
        check("t2_fallback", 32'(rand_fallback), 32'd0);
        check("t2_en_cycles", 32'(en), 32'd16);
        req = '0;

        // Fallback with MAX_TRIES=2, limit 0x10.
        do_reset();
        limit2 = 32'h0000_0010;
        req2   = 4'b0001;
        c = 0;
        while (!rand_valid2 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("t3_latency", 32'(c), 32'd19);
        check("t3_data", 32'(rand_data2), 32'h00);
        check("t3_fallback", 32'(rand_fallback2), 32'd1);
        check("t3_gnt", 32'(gnt2), 32'h1);
        req2 = '0;

        // Limit 0x01 can never be met: four draws, then fallback.
        limit = 32'h0000_0001;
        req   = 4'b0001;
        @(negedge clk);
        wait_valid(80, 1, c, en);
        check("t3b_latency", 32'(c), 32'd37);
        check("t3b_data", 32'(rand_data), 32'h00);
        check("t3b_fallback", 32'(rand_fallback), 32'd1);
        req = '0;

        // Round-robin with req=1011 held, then 1001.
        do_reset();
        limit = '0;
        req   = 4'b1011;
        wait_valid(60, 0, c, en);
        check("rr1_latency", 32'(c), 32'd10);
        check("rr1_gnt", 32'(gnt), 32'b0001);
        check("rr1_data", 32'(rand_data), 32'hE0);
        @(negedge clk);
        wait_valid(60, 0, c, en);
        check("rr2_latency", 32'(c), 32'd10);
        check("rr2_gnt", 32'(gnt), 32'b0010);
        check("rr2_data", 32'(rand_data), 32'hC5);
        @(negedge clk);
        wait_valid(60, 0, c, en);
        check("rr3_latency", 32'(c), 32'd10);
        check("rr3_gnt", 32'(gnt), 32'b1000);
        req = 4'b1001;
        @(negedge clk);
        wait_valid(60, 0, c, en);
        check("rr4_gnt", 32'(gnt), 32'b0001);
        req = '0;

        // Reset pulsed in the fourth STEP cycle.
        do_reset();
        limit = '0;
        req   = 4'b0001;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        wait_valid(60, 0, c, en);
        check("midrst_latency", 32'(c), 32'd10);
        check("midrst_gnt", 32'(gnt), 32'h1);
        check("midrst_data", 32'(rand_data), 32'hE0);
        req = '0;

        // req[0] dropped during STEP: delivery still goes to requester 0.
        do_reset();
        limit = '0;
        req   = 4'b0001;
        repeat (3) @(negedge clk);
        req = '0;
        wait_valid(60, 3, c, en);
        check("drop_latency", 32'(c), 32'd10);
        check("drop_gnt", 32'(gnt), 32'h1);
        check("drop_data", 32'(rand_data), 32'hE0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
